miner_uart_link: RTL and testbench

//  UART link between the host and the SHA-256 miner core; a single instance holds both directions.
//  RX: assembles 64 received bytes into a 512-bit job: midstate[255:0] and data2[255:0].
//  TX: sends the 32-bit golden nonce back as 4 bytes.
//  The link runs in the hash clock domain. The clock comes from an external PLL and is not generated here.

---
 rtl/miner_uart_link.sv | 245 ++++++++++++++++++++++++
 tb/tb_miner_uart_link.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/miner_uart_link.sv
`default_nettype none
// ============================================================================
//  Module   : miner_uart_link
//  Purpose  : Host <-> SHA-256 miner UART link in the hash clock domain.
//             RX assembles 64 bytes (8N1) into a 512-bit job that is split
//             into midstate[255:0] and data2[255:0]. TX returns a 32-bit
//             golden nonce as four 8N1 bytes, least significant byte first.
//  Ports    : clk      - hash clock, rising edge
//             reset_n  - synchronous active-low reset
//             RxD      - asynchronous UART input, idle high
//             midstate - job midstate from the last complete frame
//             data2    - job tail from the last complete frame
//             send     - transmit request, sampled every cycle
//             word     - nonce to transmit
//             busy     - transmit in progress
//             TxD      - UART output, idle high
//  Revision : 1.0 - initial release
// ============================================================================
module miner_uart_link #(
    parameter int CLKS_PER_BIT = 434,
    parameter int RX_IDLE_BITS = 100
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         RxD,
    output logic [255:0] midstate,
    output logic [255:0] data2,
    input  logic         send,
    input  logic [31:0]  word,
    output logic         busy,
    output logic         TxD
);
    localparam int C_BIT_W       = $clog2(CLKS_PER_BIT);
    localparam int C_IDLE_CYCLES = RX_IDLE_BITS * CLKS_PER_BIT;
    localparam int C_IDLE_W      = $clog2(C_IDLE_CYCLES);

    localparam logic [C_BIT_W-1:0]  C_BIT_LAST  = C_BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [C_BIT_W-1:0]  C_HALF_LAST = C_BIT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [C_BIT_W-1:0]  C_BIT_ONE   = C_BIT_W'(1);
    localparam logic [C_IDLE_W-1:0] C_IDLE_LAST = C_IDLE_W'(C_IDLE_CYCLES - 1);
    localparam logic [C_IDLE_W-1:0] C_IDLE_ONE  = C_IDLE_W'(1);

    localparam logic [1:0] C_RX_IDLE  = 2'd0;
    localparam logic [1:0] C_RX_START = 2'd1;
    localparam logic [1:0] C_RX_DATA  = 2'd2;
    localparam logic [1:0] C_RX_STOP  = 2'd3;

    localparam logic       C_TX_IDLE  = 1'b0;
    localparam logic       C_TX_BUSY  = 1'b1;

    // ---------------- RX state ----------------
    logic                rx_meta_q,   rx_meta_d;
    logic                rx_sync_q,   rx_sync_d;
    logic                rx_prev_q,   rx_prev_d;
    logic [1:0]          rx_state_q,  rx_state_d;
    logic [C_BIT_W-1:0]  rx_clk_q,    rx_clk_d;
    logic [2:0]          rx_bit_q,    rx_bit_d;
    logic [7:0]          rx_byte_q,   rx_byte_d;
    logic [5:0]          byte_cnt_q,  byte_cnt_d;
    logic [511:0]        shift_q,     shift_d;
    logic                frame_done_q, frame_done_d;
    logic [C_IDLE_W-1:0] idle_q,      idle_d;
    logic [255:0]        midstate_q,  midstate_d;
    logic [255:0]        data2_q,     data2_d;

    // ---------------- TX state ----------------
    logic                tx_state_q,  tx_state_d;
    logic [C_BIT_W-1:0]  tx_clk_q,    tx_clk_d;
    logic [5:0]          tx_bit_q,    tx_bit_d;
    logic [39:0]         tx_frame_q,  tx_frame_d;
    logic                txd_q,       txd_d;

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= C_RX_IDLE;
            rx_clk_q     <= '0;
            rx_bit_q     <= '0;
            rx_byte_q    <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            frame_done_q <= 1'b0;
            idle_q       <= '0;
            midstate_q   <= '0;
            data2_q      <= '0;
            tx_state_q   <= C_TX_IDLE;
            tx_clk_q     <= '0;
            tx_bit_q     <= '0;
            tx_frame_q   <= '0;
            txd_q        <= 1'b1;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_prev_d;
            rx_state_q   <= rx_state_d;
            rx_clk_q     <= rx_clk_d;
            rx_bit_q     <= rx_bit_d;
            rx_byte_q    <= rx_byte_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            frame_done_q <= frame_done_d;
            idle_q       <= idle_d;
            midstate_q   <= midstate_d;
            data2_q      <= data2_d;
            tx_state_q   <= tx_state_d;
            tx_clk_q     <= tx_clk_d;
            tx_bit_q     <= tx_bit_d;
            tx_frame_q   <= tx_frame_d;
            txd_q        <= txd_d;
        end
    end

    // ---------------- RX next state ----------------
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            // Edge (not level) detect so a line stuck low after a framing
            // error cannot immediately retrigger a byte.
            C_RX_IDLE:  if (rx_prev_q && !rx_sync_q) rx_state_d = C_RX_START;
            C_RX_START: if (rx_clk_q == C_HALF_LAST)
                            rx_state_d = rx_sync_q ? C_RX_IDLE : C_RX_DATA;
            C_RX_DATA:  if (rx_clk_q == C_BIT_LAST && rx_bit_q == 3'd7)
                            rx_state_d = C_RX_STOP;
            C_RX_STOP:  if (rx_clk_q == C_BIT_LAST) rx_state_d = C_RX_IDLE;
            default:    rx_state_d = C_RX_IDLE;
        endcase
    end

    // ---------------- RX datapath / outputs ----------------
    always_comb begin
        rx_meta_d    = RxD;
        rx_sync_d    = rx_meta_q;
        rx_prev_d    = rx_sync_q;
        rx_clk_d     = rx_clk_q + C_BIT_ONE;
        rx_bit_d     = rx_bit_q;
        rx_byte_d    = rx_byte_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        frame_done_d = 1'b0;
        idle_d       = '0;
        midstate_d   = midstate_q;
        data2_d      = data2_q;

        // Both halves load from the already-shifted buffer in one edge.
        if (frame_done_q) begin
            midstate_d = shift_q[511:256];
            data2_d    = shift_q[255:0];
        end

        case (rx_state_q)
            C_RX_IDLE: begin
                rx_clk_d = '0;
                rx_bit_d = '0;
                if (byte_cnt_q != '0) begin
                    if (idle_q == C_IDLE_LAST) begin
                        byte_cnt_d = '0;
                    end else begin
                        idle_d = idle_q + C_IDLE_ONE;
                    end
                end
            end
            C_RX_START: begin
                if (rx_clk_q == C_HALF_LAST) rx_clk_d = '0;
            end
            C_RX_DATA: begin
                if (rx_clk_q == C_BIT_LAST) begin
                    rx_clk_d  = '0;
                    rx_byte_d = {rx_sync_q, rx_byte_q[7:1]};
                    rx_bit_d  = rx_bit_q + 3'd1;
                end
            end
            C_RX_STOP: begin
                if (rx_clk_q == C_BIT_LAST) begin
                    rx_clk_d = '0;
                    if (rx_sync_q) begin
                        shift_d      = {shift_q[503:0], rx_byte_q};
                        byte_cnt_d   = byte_cnt_q + 6'd1;
                        frame_done_d = (byte_cnt_q == 6'd63);
                    end else begin
                        byte_cnt_d   = '0;
                    end
                end
            end
            default: rx_clk_d = '0;
        endcase
    end

    // ---------------- TX next state ----------------
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            C_TX_IDLE: if (send) tx_state_d = C_TX_BUSY;
            C_TX_BUSY: if (tx_clk_q == C_BIT_LAST && tx_bit_q == 6'd39)
                           tx_state_d = C_TX_IDLE;
            default:   tx_state_d = C_TX_IDLE;
        endcase
    end

    // ---------------- TX datapath / outputs ----------------
    always_comb begin
        tx_clk_d   = tx_clk_q;
        tx_bit_d   = tx_bit_q;
        tx_frame_d = tx_frame_q;
        txd_d      = txd_q;
        case (tx_state_q)
            C_TX_IDLE: begin
                if (send) begin
                    // Whole 40-bit line image is latched up front, so word
                    // changes during the transfer cannot leak into it.
                    tx_frame_d = {1'b1, word[31:24], 1'b0,
                                  1'b1, word[23:16], 1'b0,
                                  1'b1, word[15:8],  1'b0,
                                  1'b1, word[7:0],   1'b0};
                    tx_clk_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = 1'b0;
                end
            end
            C_TX_BUSY: begin
                if (tx_clk_q == C_BIT_LAST) begin
                    tx_clk_d = '0;
                    if (tx_bit_q == 6'd39) begin
                        txd_d    = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 6'd1;
                        txd_d    = tx_frame_q[tx_bit_q + 6'd1];
                    end
                end else begin
                    tx_clk_d = tx_clk_q + C_BIT_ONE;
                end
            end
            default: txd_d = 1'b1;
        endcase
    end

    assign midstate = midstate_q;
    assign data2    = data2_q;
    assign busy     = tx_state_q;
    assign TxD      = txd_q;

endmodule
`default_nettype wire

// File: tb/tb_miner_uart_link.sv
`default_nettype none
// ============================================================================
//  Module   : tb_miner_uart_link
//  Purpose  : Self-checking bench for miner_uart_link. Expected RX frames and
//             TX bytes are queued when stimulus is driven and compared when
//             the DUT outputs change or a TX byte is decoded from TxD.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_miner_uart_link;
    localparam int CPB       = 16;
    localparam int IDLE_BITS = 20;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         RxD = 1'b1;
    logic         send = 1'b0;
    logic [31:0]  word = '0;
    logic [255:0] midstate;
    logic [255:0] data2;
    logic         busy;
    logic         TxD;

    int total = 0;
    int bad   = 0;
    int updates = 0;
    logic mon_en = 1'b0;

    logic [511:0] frame_q[$];
    logic [7:0]   txb_q[$];

    always #5 clk = ~clk;

    miner_uart_link #(
        .CLKS_PER_BIT (CPB),
        .RX_IDLE_BITS (IDLE_BITS)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .RxD      (RxD),
        .midstate (midstate),
        .data2    (data2),
        .send     (send),
        .word     (word),
        .busy     (busy),
        .TxD      (TxD)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_data(input logic [7:0] b);
        RxD = 1'b0;
        clks(CPB);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            clks(CPB);
        end
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop);
        rx_data(b);
        RxD = stop;
        clks(CPB);
        RxD = 1'b1;
    endtask

    task automatic rx_frame(input logic [511:0] f);
        for (int i = 0; i < 64; i++) rx_byte(f[511 - 8*i -: 8], 1'b1);
    endtask

    // Output monitor: every change of {midstate,data2} must be the next
    // queued frame, which also catches non-atomic half updates.
    initial begin : mon_rx
        logic [511:0] prev;
        logic [511:0] cur;
        wait (mon_en);
        prev = {midstate, data2};
        forever begin
            @(negedge clk);
            cur = {midstate, data2};
            if (cur !== prev) begin
                updates++;
                if (frame_q.size() == 0) check("frame_unexpected", 512'(frame_q.size()), 512'd1);
                else                     check("frame_out", cur, frame_q.pop_front());
                prev = cur;
            end
        end
    end

    // TxD decoder: samples each bit near its centre.
    initial begin : mon_tx
        logic [7:0] b;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (TxD === 1'b0) begin
                repeat (CPB/2 - 1) @(negedge clk);
                check("tx_start", 512'(TxD), 512'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = TxD;
                end
                repeat (CPB) @(negedge clk);
                check("tx_stop", 512'(TxD), 512'd1);
                if (txb_q.size() == 0) check("tx_unexpected", 512'(txb_q.size()), 512'd1);
                else                   check("tx_byte", 512'(b), 512'(txb_q.pop_front()));
            end
        end
    end

    initial begin : mon_busy
        int n;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (busy) begin
                n = 0;
                while (busy && n < 2000) begin
                    n++;
                    @(negedge clk);
                end
                check("busy_len", 512'(n), 512'(40*CPB));
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not complete in time");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [511:0] f;
        logic [511:0] g;
        int w;

        // 1. reset
        reset_n = 1'b0;
        clks(3);
        check("rst_midstate", 512'(midstate), 512'd0);
        check("rst_data2",    512'(data2),    512'd0);
        check("rst_busy",     512'(busy),     512'd0);
        check("rst_txd",      512'(TxD),      512'd1);
        reset_n = 1'b1;
        clks(1);
        mon_en = 1'b1;
        clks(2*CPB);

        // 2. counting frame 00..3F, with update-timing checks
        for (int i = 0; i < 64; i++) f[511 - 8*i -: 8] = 8'(i);
        frame_q.push_back(f);
        for (int i = 0; i < 63; i++) rx_byte(f[511 - 8*i -: 8], 1'b1);
        rx_data(f[7:0]);
        check("t2_hold", 512'(midstate), 512'd0);
        RxD = 1'b1;
        clks(CPB);
        check("t2_midstate", 512'(midstate), 512'(f[511:256]));
        check("t2_data2",    512'(data2),    512'(f[255:0]));

        // 3. partial frame aborted by line-idle timeout
        for (int i = 0; i < 63; i++) rx_byte(8'(8'h80 + i), 1'b1);
        clks(25*CPB);
        check("t3_partial_hidden", 512'(midstate), 512'(f[511:256]));
        g = {64{8'hA5}};
        frame_q.push_back(g);
        rx_frame(g);
        clks(CPB);
        check("t3_midstate", 512'(midstate), 512'(g[511:256]));
        check("t3_data2",    512'(data2),    512'(g[255:0]));

        // 4. framing error on byte 10, then a clean frame
        for (int i = 0; i < 10; i++) rx_byte(8'(8'h40 + i), 1'b1);
        rx_byte(8'h5A, 1'b0);
        clks(2*CPB);
        for (int i = 0; i < 64; i++) f[511 - 8*i -: 8] = 8'(i*7 + 3);
        frame_q.push_back(f);
        rx_frame(f);
        clks(CPB);
        check("t4_midstate", 512'(midstate), 512'(f[511:256]));
        check("t4_data2",    512'(data2),    512'(f[255:0]));

        // 5/6. transmit nonce; second request while busy is ignored
        word = 32'h12345678;
        send = 1'b1;
        txb_q.push_back(8'h78);
        txb_q.push_back(8'h56);
        txb_q.push_back(8'h34);
        txb_q.push_back(8'h12);
        clks(1);
        send = 1'b0;
        check("t5_busy_rise", 512'(busy), 512'd1);
        clks(100);
        word = 32'hDEADBEEF;
        send = 1'b1;
        clks(1);
        send = 1'b0;
        w = 0;
        while (busy && w < 1000) begin
            clks(1);
            w++;
        end
        check("t5_busy_fell", 512'(busy), 512'd0);
        clks(200);
        check("t6_txd_idle", 512'(TxD), 512'd1);

        check("frames_left", 512'(frame_q.size()), 512'd0);
        check("tx_left",     512'(txb_q.size()),   512'd0);
        check("updates",     512'(updates),        512'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
